fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ROM_BASE, default 16'hC000, byte address of ROM word index 0.
REQ-002 SHALL have parameter RESET_VECTOR, default 16'hFFFE, byte address of the reset vector.
REQ-003 SHALL have parameter DEPTH, default 2, instruction buffer entries.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rom_addr  output  16  ROM word index, (pc - ROM_BASE) >> 1.
REQ-007 SHALL have port rom_bw  output  1  ROM byte/word select, constant 0 (word).
REQ-008 SHALL have port rom_out  input  16  ROM read data, combinational from rom_addr.
REQ-009 SHALL have port ins_valid  output  1  head buffer entry is valid.
REQ-010 SHALL have port ins_ready  input  1  decoder accepts head entry.
REQ-011 SHALL have port ins_word  output  16  head instruction word.
REQ-012 SHALL have port ins_pc  output  16  byte address of ins_word.
REQ-013 SHALL have port redirect  input  1  branch/jump taken, restart fetch.
REQ-014 SHALL have port redirect_pc  input  16  new fetch byte address.
REQ-015 SHALL have port fetch_fault  output  1  sticky out-of-ROM fetch flag.

Function
REQ-016 SHALL implement states VEC and FETCH; VEC follows reset.
REQ-017 In VEC, rom_addr SHALL index RESET_VECTOR; at the next edge pc SHALL load rom_out & 16'hFFFE and the state SHALL go to FETCH.
REQ-018 In FETCH, when the buffer is not full or a pop occurs in the same cycle, the buffer SHALL write {pc, rom_out} and pc SHALL advance by 2.
REQ-019 When the buffer is full with no pop, pc SHALL hold and no write SHALL occur.
REQ-020 ins_valid SHALL equal buffer-not-empty; a pop SHALL occur iff ins_valid and ins_ready.
REQ-021 Simultaneous push and pop on a full buffer SHALL keep occupancy at DEPTH with order preserved.
REQ-022 pc SHALL wrap modulo 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-023 In FETCH, redirect SHALL take priority: flush buffer, pc <= redirect_pc & 16'hFFFE, no write and no pop that cycle.
REQ-024 After a redirect sampled at edge E, ins_valid SHALL be 0 until edge E+1 and SHALL be 1 after edge E+1, with ins_pc = redirect_pc & 16'hFFFE.
REQ-025 redirect SHALL be ignored in VEC.
REQ-026 After reset release, the first ins_valid SHALL occur after the second edge (vector load, then first write).

Reset
REQ-027 When rst_n is low at an edge: state = VEC, pc = 0, buffer empty, ins_valid = 0, fetch_fault = 0.
REQ-028 ins_word and ins_pc SHALL read 16'h0000 while the buffer is empty.
REQ-029 Reset mid-operation SHALL discard all buffered entries and restart at VEC.

Configuration
REQ-030 With FETCH_BOUNDS_CHECK_EN defined, a FETCH cycle with pc < ROM_BASE SHALL perform no write and no pc advance, and SHALL set fetch_fault.
REQ-031 fetch_fault SHALL stay set until reset or redirect; a redirect SHALL clear it.
REQ-032 Without FETCH_BOUNDS_CHECK_EN, fetch_fault SHALL be constant 0 and rom_addr SHALL be computed modulo 2^16 with no check.

Structure
REQ-033 Package fetch_pkg SHALL hold the state encoding (VEC, FETCH), the ROM_BASE and RESET_VECTOR defaults, and the buffer entry width (32).
REQ-034 The buffer SHALL be a sub-module fetch_fifo (DEPTH x 32, push/pop/flush, full/empty).

Verification
ROM image for all scenarios: [16'hFFFE] = 16'hC000, [16'hC000] = 16'h4031, [16'hC002] = 16'h0400, [16'hC004] = 16'h4303.
REQ-035 Reset release with ins_ready = 1 -> ins_valid rises after the 2nd edge with ins_pc/ins_word = C000/4031, then C002/0400 and C004/4303 on consecutive cycles.
REQ-036 ins_ready = 0 for 5 cycles -> occupancy stops at 2, pc holds at 16'hC004; ins_ready = 1 -> words emerge in order with no loss.
REQ-037 redirect = 1 with redirect_pc = 16'hC003 while the buffer is full -> buffer flushed; after the next edge ins_pc = C002, ins_word = 0400.
REQ-038 redirect_pc = 16'hFFFE -> entries FFFE/C000, then pc = 0000; with FETCH_BOUNDS_CHECK_EN, fetch_fault = 1 and no further ins_valid.
REQ-039 rst_n low for one edge mid-stream with a full buffer -> ins_valid = 0 next cycle, restart identical to REQ-035.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   state_e          - fetch FSM state encoding (VEC, FETCH)
//   ROM_BASE_DEF     - default byte address of ROM word index 0
//   RESET_VECTOR_DEF - default byte address of the reset vector
//   ENTRY_W          - instruction buffer entry width, {pc[15:0], word[15:0]}
package fetch_pkg;

    typedef enum logic {
        VEC   = 1'b0,
        FETCH = 1'b1
    } state_e;

    localparam logic [15:0] ROM_BASE_DEF     = 16'hC000;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFE;
    localparam int unsigned ENTRY_W          = 32;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular instruction buffer.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset (empties the buffer)
//   push, wdata    - write request; accepted when not full or when a pop
//                    happens in the same cycle
//   pop            - remove head entry (ignored when empty)
//   flush          - discard all entries; overrides push and pop
//   rdata          - head entry, all zeros while empty
//   full, empty    - occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer increment with wrap, valid for non-power-of-two depths.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch from a word ROM into a small
// buffer, with redirect (branch) support.
// After reset the unit reads the reset vector (VEC), then streams words
// from consecutive even byte addresses (FETCH) into a DEPTH-entry buffer.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   rom_addr, rom_bw      - ROM word index ((addr - ROM_BASE) >> 1), word mode
//   rom_out               - ROM data, combinational from rom_addr
//   ins_valid/ready       - head-of-buffer handshake to the decoder
//   ins_word, ins_pc      - head instruction and its byte address (0 if empty)
//   redirect, redirect_pc - flush and restart fetch at redirect_pc (even)
//   fetch_fault           - sticky out-of-ROM fetch flag
// Build option: define FETCH_BOUNDS_CHECK_EN to stall and flag fetches with
// pc below ROM_BASE; otherwise fetch_fault is tied to 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] ROM_BASE     = ROM_BASE_DEF,
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    output logic        rom_bw,
    input  logic [15:0] rom_out,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_word,
    output logic [15:0] ins_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        fetch_fault
);

    state_e              state_q, state_d;
    logic [15:0]         pc_q, pc_d;
    logic [15:0]         lookup_addr;
    logic                in_bounds;
    logic                buf_push, buf_pop, buf_flush;
    logic                buf_full, buf_empty;
    logic [ENTRY_W-1:0]  buf_wdata, buf_rdata;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic                fault_q, fault_d;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (buf_flush),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign rom_bw    = 1'b0;
    assign ins_valid = !buf_empty;
    assign ins_pc    = buf_rdata[31:16];
    assign ins_word  = buf_rdata[15:0];
    assign buf_wdata = {pc_q, rom_out};

    // ROM index is plain modulo-2^16 arithmetic; the bounds check (if
    // built) gates the write, not the address.
    always_comb begin
        lookup_addr = (state_q == VEC) ? RESET_VECTOR : pc_q;
        rom_addr    = 16'(lookup_addr - ROM_BASE) >> 1;
    end

    always_comb begin
`ifdef FETCH_BOUNDS_CHECK_EN
        in_bounds = (pc_q >= ROM_BASE);
        fault_d   = fault_q;
`else
        in_bounds = 1'b1;
`endif
        state_d   = state_q;
        pc_d      = pc_q;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        buf_flush = 1'b0;
        unique case (state_q)
            VEC: begin
                pc_d    = rom_out & 16'hFFFE;
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // Redirect wins over both the pop and the write.
                    buf_flush = 1'b1;
                    pc_d      = redirect_pc & 16'hFFFE;
`ifdef FETCH_BOUNDS_CHECK_EN
                    fault_d   = 1'b0;
`endif
                end else begin
                    buf_pop = ins_valid && ins_ready;
                    if (!in_bounds) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                        fault_d = 1'b1;
`endif
                    end else if (!buf_full || buf_pop) begin
                        buf_push = 1'b1;
                        pc_d     = pc_q + 16'd2;
                    end
                end
            end
            default: state_d = VEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= VEC;
            pc_q    <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// The reference model treats the accepted instruction stream as consecutive
// even addresses starting at the reset-vector target or the redirect target;
// each restart refills the expected queue, the monitor pops on handshakes.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic        rom_bw;
    logic [15:0] rom_out;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_word;
    logic [15:0] ins_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        fetch_fault;
    logic [15:0] rom_byte;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_pops   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .ROM_BASE     (16'hC000),
        .RESET_VECTOR (16'hFFFE),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_bw      (rom_bw),
        .rom_out     (rom_out),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_word    (ins_word),
        .ins_pc      (ins_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    // ROM image: fixed words at the four scenario addresses, a scrambled
    // address pattern elsewhere so every fetched word is distinguishable.
    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        case (a)
            16'hFFFE: return 16'hC000;
            16'hC000: return 16'h4031;
            16'hC002: return 16'h0400;
            16'hC004: return 16'h4303;
            default:  return {a[7:0], a[15:8]} ^ 16'h1234;
        endcase
    endfunction

    assign rom_byte = 16'hC000 + {rom_addr[14:0], 1'b0};
    assign rom_out  = rom_fn(rom_byte);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected accepted stream from a restart point.
    task automatic restart_model(input logic [15:0] start);
        logic [15:0] p;
        exp_q.delete();
        p = start & 16'hFFFE;
        for (int i = 0; i < 64; i++) begin
            if (BOUNDS && p < 16'hC000) break;
            exp_q.push_back({p, rom_fn(p)});
            p = p + 16'd2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshake at the coming edge retires the head entry.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rom_bw", {31'd0, rom_bw}, 32'd0);
            if (!ins_valid) begin
                chk("empty_outputs", {ins_pc, ins_word}, 32'd0);
            end else if (ins_ready && !redirect) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: got %h expected no entry", {ins_pc, ins_word});
                end else begin
                    chk("stream", {ins_pc, ins_word}, exp_q.pop_front());
                end
            end
        end
    end

    int since_redir;
    int since_rst;

    initial begin
        rst_n       = 1'b0;
        ins_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        restart_model(rom_fn(16'hFFFE));
        tick();
        tick();
        chk("reset_valid", {31'd0, ins_valid}, 32'd0);
        chk("reset_head", {ins_pc, ins_word}, 32'd0);
        chk("reset_fault", {31'd0, fetch_fault}, 32'd0);

        // Release; a redirect during VEC must be ignored.
        rst_n       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hC080;
        tick();
        redirect = 1'b0;
        chk("vec_valid", {31'd0, ins_valid}, 32'd0);
        chk("vec_pc_loaded", {16'd0, rom_addr}, 32'd0);
        tick();
        chk("first_valid", {31'd0, ins_valid}, 32'd1);
        chk("first_head", {ins_pc, ins_word}, 32'hC000_4031);
        tick();
        chk("second_head", {ins_pc, ins_word}, 32'hC002_0400);
        tick();
        chk("third_head", {ins_pc, ins_word}, 32'hC004_4303);

        // Stall to fill, then reset mid-stream with a full buffer.
        ins_ready = 1'b0;
        repeat (4) tick();
        chk("full_pc_hold", {16'd0, rom_addr}, 32'((16'hC004 + 16'(2 * DEPTH) - 16'hC000) >> 1));
        rst_n = 1'b0;
        restart_model(rom_fn(16'hFFFE));
        tick();
        chk("midreset_valid", {31'd0, ins_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("restart_vec_valid", {31'd0, ins_valid}, 32'd0);
        tick();
        chk("restart_first", {ins_pc, ins_word}, 32'hC000_4031);
        repeat (5) tick();
        chk("stall_pc_hold", {16'd0, rom_addr}, 32'(DEPTH));
        chk("stall_head", {ins_pc, ins_word}, 32'hC000_4031);
        ins_ready = 1'b1;
        repeat (6) tick();

        // Redirect to an odd address while full.
        ins_ready = 1'b0;
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_pc = 16'hC003;
        restart_model(16'hC003);
        tick();
        redirect  = 1'b0;
        ins_ready = 1'b1;
        chk("redir_flush", {31'd0, ins_valid}, 32'd0);
        tick();
        chk("redir_head", {ins_pc, ins_word}, 32'hC002_0400);
        repeat (3) tick();

        // Redirect to the top of memory: wrap to 0000.
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        restart_model(16'hFFFE);
        tick();
        redirect = 1'b0;
        chk("wrap_flush", {31'd0, ins_valid}, 32'd0);
        tick();
        chk("wrap_head", {ins_pc, ins_word}, 32'hFFFE_C000);
        tick();
        if (BOUNDS) begin
            chk("bounds_valid", {31'd0, ins_valid}, 32'd0);
            chk("bounds_fault", {31'd0, fetch_fault}, 32'd1);
            repeat (3) tick();
            chk("bounds_valid_hold", {31'd0, ins_valid}, 32'd0);
            chk("bounds_fault_hold", {31'd0, fetch_fault}, 32'd1);
        end else begin
            chk("wrap_pc0", {ins_pc, ins_word}, {16'h0000, rom_fn(16'h0000)});
            chk("nobounds_fault", {31'd0, fetch_fault}, 32'd0);
        end
        redirect    = 1'b1;
        redirect_pc = 16'hC000;
        restart_model(16'hC000);
        tick();
        redirect = 1'b0;
        chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);

        // Randomized traffic.
        n_pops      = 0;
        since_redir = 0;
        since_rst   = 10;
        for (int c = 0; c < 1000; c++) begin
            since_redir++;
            since_rst++;
            if ($urandom_range(0, 199) == 0) begin
                rst_n     = 1'b0;
                redirect  = 1'b0;
                restart_model(rom_fn(16'hFFFE));
                since_rst   = 0;
                since_redir = 0;
            end else begin
                rst_n = 1'b1;
                if (since_rst >= 3 && (since_redir >= 30 || $urandom_range(0, 15) == 0)) begin
                    redirect    = 1'b1;
                    redirect_pc = 16'hC000 + 16'($urandom_range(0, 255));
                    restart_model(redirect_pc);
                    since_redir = 0;
                end else begin
                    redirect = 1'b0;
                end
            end
            ins_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n    = 1'b1;
        redirect = 1'b0;
        tick();
        chk("random_fault", {31'd0, fetch_fault}, 32'd0);
        chk("random_progress", {31'd0, n_pops > 300}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
